regfile_write_buffer: RTL and testbench
=======================================

Name: regfile_write_buffer

Overview:
- Small in-order FIFO that sits directly upstream of the register file's write port.
- Accepts write-back requests (address, data) from the execute stage over a valid/ready handshake.
- Drains one entry per cycle into the register file's write path (address decoder plus per-register write enable/d inputs).
- Reports per-read-port whether a read address still has an undrained write pending, so the issue logic can stall on hazards.

Parameters:
- width, 32, bits per data word (matches register data width)
- addr_width, 5, register address bits (32 registers; address 0 is the hardwired-zero register)
- depth, 4, number of buffer entries; power of two, minimum 2

Ports:
- clk  input  1  clock; all state updates on posedge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  upstream write request valid
- in_ready  output  1  buffer can accept a request this cycle
- in_addr  input  addr_width  destination register of request
- in_data  input  width  data of request
- hold  input  1  when high, suppresses draining this cycle
- wr_enable  output  1  write strobe to register file
- wr_addr  output  addr_width  register file write address
- wr_data  output  width  register file write data
- rd_addr1  input  addr_width  read port 1 address under hazard check
- rd_addr2  input  addr_width  read port 2 address under hazard check
- rd_pending1  output  1  an undrained entry targets rd_addr1
- rd_pending2  output  1  an undrained entry targets rd_addr2
- count  output  clog2(depth)+1  number of valid entries
- empty  output  1  count == 0
- full  output  1  count == depth

Behaviour:
- Reset (reset high at posedge): head pointer, tail pointer and count go to 0; all entry valid bits are cleared; entry data is don't-care.
- Reset mid-operation discards all pending writes; none reach the register file.
- While reset is high: in_ready=0 and wr_enable=0 combinationally.
- After reset: empty=1, full=0, count=0, in_ready=1, wr_enable=0, rd_pending1/2=0.
- in_ready = !full && !reset. The ready signal does not depend on a same-cycle drain, so there is no push when full even if a pop occurs that cycle.
- Accept on posedge when in_valid && in_ready.
  - If in_addr == 0: the request is accepted (handshake completes) but discarded. Nothing is enqueued and count is unchanged.
  - Otherwise: the entry is written at the tail, the tail increments modulo depth, and the entry's valid bit is set.
- Drain is combinational from the head entry:
  - wr_enable = !empty && !hold && !reset.
  - wr_addr and wr_data equal the head entry's fields.
  - When wr_enable=0, wr_addr and wr_data hold the head fields (or 0 when empty); they are don't-care for the register file.
- On a posedge with wr_enable=1, the register file captures the write and the buffer pops in the same edge: head increments modulo depth and the valid bit clears.
- Latency: a request accepted at edge N drives wr_enable during cycle N+1 at the earliest (empty buffer, hold=0), and lands in the register at edge N+1.
- Simultaneous push and pop (not full): count is unchanged and both pointers advance.
- Push of address 0 while a pop occurs: count decrements by 1.
- Ordering: strict FIFO. Two writes to the same register drain in arrival order, so the later value persists.
- Pointers wrap from depth-1 to 0. Full and empty are derived from count, never from pointer equality alone.
- Hazard flags: rd_pendingN = (rd_addrN != 0) && (some valid entry has addr == rd_addrN). The flags are combinational, and an entry being drained in the current cycle still counts as pending.
- hold has no effect on accept.
- Invariant: count never exceeds depth or underflows.

Optional Feature:
- Macro: REGFILE_WRITE_BUFFER_BYPASS_EN
- Defined: adds outputs rd_bypass1 and rd_bypass2 (width each).
  - rd_bypassN = data of the youngest valid entry whose addr == rd_addrN; 0 if there is no match or rd_addrN == 0.
  - Lets the consumer forward instead of stall. rd_pendingN is unchanged.
- Undefined: these ports and the priority-select logic do not exist; rd_pendingN is the only hazard indication.

Test Plan:
- Reset then idle: assert reset 2 cycles -> count=0, empty=1, in_ready=1 after release, wr_enable=0, rd_pending1=rd_pending2=0.
- Single write: push addr=5, data=0xDEADBEEF at edge N, hold=0 -> cycle N+1 shows wr_enable=1, wr_addr=5, wr_data=0xDEADBEEF; count=0 after edge N+1.
- Fill and back-pressure:
  - Stimulus: hold=1, push addrs 1..4, then offer addr 6.
  - Required: full=1, in_ready=0, and addr 6 is not accepted.
  - Then release hold: drains 1, 2, 3, 4 on consecutive cycles and the pointers wrap. Push 6 is accepted on the first cycle in_ready returns to 1.
- Zero-register drop: push addr=0, data=0x12345678 -> in_ready=1, count stays 0, wr_enable never asserts.
- Hazard and ordering:
  - Stimulus: hold=1, push (7, 0xA), (7, 0xB); rd_addr1=7, rd_addr2=0.
  - Required while held: rd_pending1=1, rd_pending2=0.
  - After release: writes 0xA then 0xB, and rd_pending1=0 after the second drain.
  - With REGFILE_WRITE_BUFFER_BYPASS_EN defined: rd_bypass1=0xB while both entries are pending.
- Reset mid-drain: 3 entries queued and draining, assert reset -> wr_enable=0 in that cycle; after release count=0 and no further writes appear.

Source files
------------

// File: rtl/regfile_write_buffer.sv
// regfile_write_buffer
// In-order write-back buffer that sits in front of the register file write port.
// It accepts (addr, data) requests over a valid/ready handshake and drains at most
// one entry per cycle into the register file. Writes to register 0 are accepted and
// dropped. For each read port it flags whether a queued write still targets that
// address, so the issue logic can stall on the hazard.
// Optional build macro: REGFILE_WRITE_BUFFER_BYPASS_EN adds rd_bypass1/rd_bypass2,
// which carry the data of the youngest pending write to each read address.
module regfile_write_buffer #(
    parameter int width      = 32,
    parameter int addr_width = 5,
    parameter int depth      = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [addr_width-1:0]      in_addr,
    input  logic [width-1:0]           in_data,
    input  logic                       hold,
    output logic                       wr_enable,
    output logic [addr_width-1:0]      wr_addr,
    output logic [width-1:0]           wr_data,
    input  logic [addr_width-1:0]      rd_addr1,
    input  logic [addr_width-1:0]      rd_addr2,
    output logic                       rd_pending1,
    output logic                       rd_pending2,
    output logic [$clog2(depth):0]     count,
    output logic                       empty,
    output logic                       full
`ifdef REGFILE_WRITE_BUFFER_BYPASS_EN
    ,
    output logic [width-1:0]           rd_bypass1,
    output logic [width-1:0]           rd_bypass2
`endif
);

    localparam int PW = $clog2(depth);
    localparam int CW = PW + 1;

    // Entry storage: read combinationally from every slot for hazard checks.
    logic [addr_width-1:0] addr_mem [depth];
    logic [width-1:0]      data_mem [depth];
    logic [depth-1:0]      valid_reg;

    logic [PW-1:0] head_reg;
    logic [PW-1:0] tail_reg;
    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;

    logic accept;
    logic push;
    logic pop;

    logic [depth-1:0] match1;
    logic [depth-1:0] match2;

    assign count = count_reg;
    assign empty = (count_reg == '0);
    assign full  = (count_reg == CW'(depth));

    // Ready never looks at a same-cycle drain, so a full buffer refuses even while popping.
    assign in_ready  = !full && !reset;
    assign wr_enable = !empty && !hold && !reset;

    assign accept = in_valid && in_ready;
    // Register 0 is hardwired to zero: the handshake completes but nothing is queued.
    assign push   = accept && (in_addr != '0);
    assign pop    = wr_enable;

    // Head entry is presented even while held; zero when nothing is queued.
    assign wr_addr = empty ? '0 : addr_mem[head_reg];
    assign wr_data = empty ? '0 : data_mem[head_reg];

    // Per-entry address comparison against both read ports.
    generate
        for (genvar gi = 0; gi < depth; gi++) begin : g_match
            assign match1[gi] = valid_reg[gi] && (addr_mem[gi] == rd_addr1);
            assign match2[gi] = valid_reg[gi] && (addr_mem[gi] == rd_addr2);
        end
    endgenerate

    // An entry being drained this cycle is still valid, so it still reports pending.
    assign rd_pending1 = (rd_addr1 != '0) && (|match1);
    assign rd_pending2 = (rd_addr2 != '0) && (|match2);

    // Occupancy update: push and pop in the same edge cancel out.
    always_comb begin
        count_next = count_reg;
        if (push && !pop) begin
            count_next = count_reg + CW'(1);
        end else if (!push && pop) begin
            count_next = count_reg - CW'(1);
        end
    end

    // Pointer, occupancy and valid-bit state; reset discards every pending write.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
            valid_reg <= '0;
        end else begin
            count_reg <= count_next;
            if (pop) begin
                head_reg            <= head_reg + PW'(1);
                valid_reg[head_reg] <= 1'b0;
            end
            if (push) begin
                tail_reg            <= tail_reg + PW'(1);
                valid_reg[tail_reg] <= 1'b1;
            end
        end
    end

    // Entry payload capture at the tail; contents are don't-care until marked valid.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[tail_reg] <= in_addr;
            data_mem[tail_reg] <= in_data;
        end
    end

`ifdef REGFILE_WRITE_BUFFER_BYPASS_EN
    logic [PW-1:0] byp_idx;

    // Walk from oldest (head) to youngest; later matches override earlier ones.
    always_comb begin
        rd_bypass1 = '0;
        rd_bypass2 = '0;
        byp_idx    = '0;
        for (int k = 0; k < depth; k++) begin
            byp_idx = head_reg + PW'(k);
            if (rd_addr1 != '0 && match1[byp_idx]) begin
                rd_bypass1 = data_mem[byp_idx];
            end
            if (rd_addr2 != '0 && match2[byp_idx]) begin
                rd_bypass2 = data_mem[byp_idx];
            end
        end
    end
`endif

endmodule

// File: tb/tb_regfile_write_buffer.sv
// Testbench for regfile_write_buffer: a directed cycle table covering the main
// scenarios, then randomized traffic checked against a queue-based reference model.
// Build with REGFILE_WRITE_BUFFER_BYPASS_EN to also check the bypass outputs.
module tb_regfile_write_buffer;

    localparam int W  = 32;
    localparam int AW = 5;
    localparam int D  = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_addr;
    logic [W-1:0]  in_data;
    logic          hold;
    logic          wr_enable;
    logic [AW-1:0] wr_addr;
    logic [W-1:0]  wr_data;
    logic [AW-1:0] rd_addr1;
    logic [AW-1:0] rd_addr2;
    logic          rd_pending1;
    logic          rd_pending2;
    logic [2:0]    count;
    logic          empty;
    logic          full;
`ifdef REGFILE_WRITE_BUFFER_BYPASS_EN
    logic [W-1:0]  rd_bypass1;
    logic [W-1:0]  rd_bypass2;
`endif

    always #5 clk = ~clk;

    regfile_write_buffer #(.width(W), .addr_width(AW), .depth(D)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_addr    (in_addr),
        .in_data    (in_data),
        .hold       (hold),
        .wr_enable  (wr_enable),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_addr1   (rd_addr1),
        .rd_addr2   (rd_addr2),
        .rd_pending1(rd_pending1),
        .rd_pending2(rd_pending2),
        .count      (count),
        .empty      (empty),
        .full       (full)
`ifdef REGFILE_WRITE_BUFFER_BYPASS_EN
        ,
        .rd_bypass1 (rd_bypass1),
        .rd_bypass2 (rd_bypass2)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of inputs together with the outputs required before the next edge.
    typedef struct {
        logic          rst;
        logic          v;
        logic [AW-1:0] a;
        logic [W-1:0]  d;
        logic          h;
        logic [AW-1:0] r1;
        logic [AW-1:0] r2;
        logic          we;
        logic [AW-1:0] wa;
        logic [W-1:0]  wd;
        int            cnt;
        logic          rdy;
        logic          p1;
        logic          p2;
        logic [W-1:0]  b1;
        logic [W-1:0]  b2;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic v, input int a, input logic [W-1:0] d,
                                input logic h, input int r1, input int r2,
                                input logic we, input int wa, input logic [W-1:0] wd, input int cnt,
                                input logic rdy, input logic p1, input logic p2,
                                input logic [W-1:0] b1, input logic [W-1:0] b2);
        vec_t t;
        t.rst = rst; t.v = v; t.a = AW'(a); t.d = d; t.h = h;
        t.r1 = AW'(r1); t.r2 = AW'(r2);
        t.we = we; t.wa = AW'(wa); t.wd = wd; t.cnt = cnt;
        t.rdy = rdy; t.p1 = p1; t.p2 = p2; t.b1 = b1; t.b2 = b2;
        return t;
    endfunction

    task automatic drive(input logic rst, input logic v, input logic [AW-1:0] a, input logic [W-1:0] d,
                         input logic h, input logic [AW-1:0] r1, input logic [AW-1:0] r2);
        reset = rst; in_valid = v; in_addr = a; in_data = d; hold = h;
        rd_addr1 = r1; rd_addr2 = r2;
    endtask

    task automatic check_outputs(input string tag, input logic we, input logic [AW-1:0] wa,
                                 input logic [W-1:0] wd, input int cnt, input logic rdy,
                                 input logic p1, input logic p2,
                                 input logic [W-1:0] b1, input logic [W-1:0] b2);
        chk({tag, " wr_enable"}, 32'(wr_enable), 32'(we));
        chk({tag, " count"}, 32'(count), 32'(cnt));
        chk({tag, " empty"}, 32'(empty), 32'(cnt == 0));
        chk({tag, " full"}, 32'(full), 32'(cnt == D));
        chk({tag, " in_ready"}, 32'(in_ready), 32'(rdy));
        chk({tag, " rd_pending1"}, 32'(rd_pending1), 32'(p1));
        chk({tag, " rd_pending2"}, 32'(rd_pending2), 32'(p2));
        if (we) begin
            chk({tag, " wr_addr"}, 32'(wr_addr), 32'(wa));
            chk({tag, " wr_data"}, wr_data, wd);
        end
`ifdef REGFILE_WRITE_BUFFER_BYPASS_EN
        chk({tag, " rd_bypass1"}, rd_bypass1, b1);
        chk({tag, " rd_bypass2"}, rd_bypass2, b2);
`else
        if (b1 != b2) begin end
`endif
    endtask

    vec_t vecs[$];

    // Reference model: a plain FIFO of pending (addr, data) writes.
    typedef struct {
        logic [AW-1:0] a;
        logic [W-1:0]  d;
    } ent_t;
    ent_t mq[$];

    function automatic logic m_pending(input logic [AW-1:0] r);
        if (r == 0) return 1'b0;
        foreach (mq[i]) if (mq[i].a == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [W-1:0] m_bypass(input logic [AW-1:0] r);
        if (r == 0) return '0;
        for (int i = mq.size() - 1; i >= 0; i--) if (mq[i].a == r) return mq[i].d;
        return '0;
    endfunction

    initial begin
        drive(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);

        //         rst v  a   d             h  r1  r2 | we wa  wd            cnt rdy p1 p2 b1            b2
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 0,  0,  0, 0,  32'h0,        0, 0, 0, 0, 32'h0,        32'h0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0,  0,  0, 0,  32'h0,        0, 1, 0, 0, 32'h0,        32'h0));
        // single write to r5
        vecs.push_back(mk(0, 1, 5, 32'hDEADBEEF, 0, 0,  0,  0, 0,  32'h0,        0, 1, 0, 0, 32'h0,        32'h0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 5,  0,  1, 5,  32'hDEADBEEF, 1, 1, 1, 0, 32'hDEADBEEF, 32'h0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0,  0,  0, 0,  32'h0,        0, 1, 0, 0, 32'h0,        32'h0));
        // fill under hold, then offer r6 while full
        vecs.push_back(mk(0, 1, 1, 32'h11,       1, 0,  0,  0, 0,  32'h0,        0, 1, 0, 0, 32'h0,        32'h0));
        vecs.push_back(mk(0, 1, 2, 32'h22,       1, 0,  0,  0, 1,  32'h11,       1, 1, 0, 0, 32'h0,        32'h0));
        vecs.push_back(mk(0, 1, 3, 32'h33,       1, 3,  2,  0, 1,  32'h11,       2, 1, 0, 1, 32'h0,        32'h22));
        vecs.push_back(mk(0, 1, 4, 32'h44,       1, 0,  0,  0, 1,  32'h11,       3, 1, 0, 0, 32'h0,        32'h0));
        vecs.push_back(mk(0, 1, 6, 32'h66,       1, 0,  0,  0, 1,  32'h11,       4, 0, 0, 0, 32'h0,        32'h0));
        // release hold: drain 1,2,3,4 then the late 6
        vecs.push_back(mk(0, 1, 6, 32'h66,       0, 0,  0,  1, 1,  32'h11,       4, 0, 0, 0, 32'h0,        32'h0));
        vecs.push_back(mk(0, 1, 6, 32'h66,       0, 0,  0,  1, 2,  32'h22,       3, 1, 0, 0, 32'h0,        32'h0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 6,  0,  1, 3,  32'h33,       3, 1, 1, 0, 32'h66,       32'h0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0,  0,  1, 4,  32'h44,       2, 1, 0, 0, 32'h0,        32'h0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0,  0,  1, 6,  32'h66,       1, 1, 0, 0, 32'h0,        32'h0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0,  0,  0, 0,  32'h0,        0, 1, 0, 0, 32'h0,        32'h0));
        // write to r0 is swallowed
        vecs.push_back(mk(0, 1, 0, 32'h12345678, 0, 0,  0,  0, 0,  32'h0,        0, 1, 0, 0, 32'h0,        32'h0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0,  0,  0, 0,  32'h0,        0, 1, 0, 0, 32'h0,        32'h0));
        // two writes to r7: hazard, bypass of youngest, in-order drain
        vecs.push_back(mk(0, 1, 7, 32'hA,        1, 7,  0,  0, 0,  32'h0,        0, 1, 0, 0, 32'h0,        32'h0));
        vecs.push_back(mk(0, 1, 7, 32'hB,        1, 7,  0,  0, 7,  32'hA,        1, 1, 1, 0, 32'hA,        32'h0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        1, 7,  0,  0, 7,  32'hA,        2, 1, 1, 0, 32'hB,        32'h0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 7,  0,  1, 7,  32'hA,        2, 1, 1, 0, 32'hB,        32'h0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 7,  0,  1, 7,  32'hB,        1, 1, 1, 0, 32'hB,        32'h0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 7,  0,  0, 0,  32'h0,        0, 1, 0, 0, 32'h0,        32'h0));
        // reset while three entries are draining
        vecs.push_back(mk(0, 1, 9, 32'h91,       1, 0,  0,  0, 0,  32'h0,        0, 1, 0, 0, 32'h0,        32'h0));
        vecs.push_back(mk(0, 1, 10, 32'h92,      1, 0,  0,  0, 9,  32'h91,       1, 1, 0, 0, 32'h0,        32'h0));
        vecs.push_back(mk(0, 1, 11, 32'h93,      1, 0,  0,  0, 9,  32'h91,       2, 1, 0, 0, 32'h0,        32'h0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0,  0,  1, 9,  32'h91,       3, 1, 0, 0, 32'h0,        32'h0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0,  0,  1, 10, 32'h92,       2, 1, 0, 0, 32'h0,        32'h0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 0,  0,  0, 11, 32'h93,       1, 0, 0, 0, 32'h0,        32'h0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 11, 0,  0, 0,  32'h0,        0, 1, 0, 0, 32'h0,        32'h0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0,  0,  0, 0,  32'h0,        0, 1, 0, 0, 32'h0,        32'h0));

        // first reset cycle: outputs are unknown until the first edge
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].v, vecs[i].a, vecs[i].d, vecs[i].h, vecs[i].r1, vecs[i].r2);
            @(negedge clk);
            $display("vec %0d: rst=%0b v=%0b a=%0d h=%0b -> we=%0b wa=%0d wd=0x%0h cnt=%0d rdy=%0b",
                     i, reset, in_valid, in_addr, hold, wr_enable, wr_addr, wr_data, count, in_ready);
            check_outputs($sformatf("vec%0d", i), vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].cnt,
                          vecs[i].rdy, vecs[i].p1, vecs[i].p2, vecs[i].b1, vecs[i].b2);
            @(posedge clk); #1;
        end

        // Randomized traffic; buffer is empty here after the final idle row.
        mq.delete();
        for (int c = 0; c < 600; c++) begin
            logic          e_rdy, e_we, r_rst, r_v, r_h;
            logic [AW-1:0] r_a, r_r1, r_r2, e_wa;
            logic [W-1:0]  r_d, e_wd;
            r_rst = ($urandom_range(0, 49) == 0);
            r_v   = ($urandom_range(0, 2) != 0);
            r_h   = ($urandom_range(0, 2) == 0);
            r_a   = AW'($urandom_range(0, 7));
            r_d   = $urandom;
            r_r1  = AW'($urandom_range(0, 7));
            r_r2  = AW'($urandom_range(0, 7));
            drive(r_rst, r_v, r_a, r_d, r_h, r_r1, r_r2);

            e_rdy = (mq.size() < D) && !r_rst;
            e_we  = (mq.size() > 0) && !r_h && !r_rst;
            e_wa  = (mq.size() > 0) ? mq[0].a : '0;
            e_wd  = (mq.size() > 0) ? mq[0].d : '0;

            @(negedge clk);
            check_outputs($sformatf("rnd%0d", c), e_we, e_wa, e_wd, mq.size(), e_rdy,
                          m_pending(r_r1), m_pending(r_r2), m_bypass(r_r1), m_bypass(r_r2));
            if (e_we) $display("rnd %0d: drain r%0d <= 0x%0h", c, e_wa, e_wd);

            @(posedge clk); #1;
            if (r_rst) begin
                mq.delete();
            end else begin
                if (e_we) void'(mq.pop_front());
                if (r_v && e_rdy && r_a != 0) mq.push_back('{a: r_a, d: r_d});
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
